// File: rtl/lin_interp_pkg.sv
// lin_interp_pkg: shared state encoding, data width and sign-extension helper
package lin_interp_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {IDLE, RAMP} state_t;
  function automatic logic signed [DATA_W:0] sext33(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction
endpackage

// File: rtl/lin_interp_acc.sv
// lin_interp_acc: ramp accumulator, delta register and floor-scaled output slice
module lin_interp_acc
  import lin_interp_pkg::*;
#(
  parameter int K = 5
) (
  input  logic              i_clock,
  input  logic              i_RESET,
  input  logic              load,
  input  logic              add,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] o_data
);
  logic signed [DATA_W:0]     delta, delta_new;
  logic signed [DATA_W+K:0]   acc, acc_load;
  always_comb begin
    delta_new = sext33(target) - sext33(base);
    acc_load  = $signed({base[DATA_W-1], base, {K{1'b0}}}) + $signed({{K{delta_new[DATA_W]}}, delta_new});
    o_data    = acc[DATA_W+K-1:K];
  end
  // Arithmetic slice of acc floors toward -inf; step N lands exactly on target
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      acc   <= '0;
      delta <= '0;
    end else if (load) begin
      acc   <= acc_load;
      delta <= delta_new;
    end else if (add) begin
      acc   <= acc + $signed({{K{delta[DATA_W]}}, delta});
    end
  end
endmodule

// File: rtl/lin_interp.sv
// lin_interp: linear interpolating upsampler, 2^LOG2_STEPS ramp points per accepted sample
module lin_interp
  import lin_interp_pkg::*;
#(
  parameter int LOG2_STEPS = 5
) (
  input  logic              i_clock,
  input  logic              i_RESET,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_strobe,
  output logic              o_last
);
  localparam int K = LOG2_STEPS;
  localparam logic [K:0] N = {1'b1, {K{1'b0}}};
  state_t            state;
  logic [K:0]        cnt;
  logic [DATA_W-1:0] y_prev;
  logic              at_end, accept, adv;
  always_comb begin
    at_end   = state == RAMP && cnt == N;
    o_ready  = state == IDLE || at_end;
    accept   = i_valid && o_ready;
    adv      = state == RAMP && !at_end;
    o_strobe = state == RAMP;
    o_last   = at_end;
  end
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      y_prev <= '0;
    end else if (accept) begin
      state  <= RAMP;
      cnt    <= (K+1)'(1);
      y_prev <= i_data;
    end else if (adv) begin
      cnt    <= cnt + 1'b1;
    end else if (at_end) begin
      state  <= IDLE;
    end
  end
  lin_interp_acc #(.K(K)) u_acc (
    .i_clock (i_clock),
    .i_RESET (i_RESET),
    .load    (accept),
    .add     (adv),
    .base    (y_prev),
    .target  (i_data),
    .o_data  (o_data)
  );
endmodule
